video_mode_ctrl: RTL and testbench
==================================

// Module: video_mode_ctrl
// PURPOSE
//  Qualifies CRTC sync timing field by field and decides the video mode the blanker runs in:
//  standard (computed border window), non-standard (sync-derived blanking) or illegal (forced blank).
//  Sits between the CRTC sync outputs and video_blanker, and drives the blanker's mode select.
//  Changes mode only after stable lock, with hysteresis, so that a CRTC register rewrite causes
//  one clean transition.
// PARAMETERS
//  LOCK_FIELDS   4    consecutive matching fields needed to enter LOCKED
//  UNLOCK_FIELDS 2    consecutive mismatching fields in LOCKED before re-search
//  TOL_H         2    allowed |hres - ref_h| in dots for a field to match
//  TOL_V         1    allowed |vres - ref_v| in lines for a field to match
//  H_STD_MIN     352  standard-mode hres window, inclusive (low bound)
//  H_STD_MAX     415  standard-mode hres window, inclusive (high bound)
//  V_STD_MIN     296  standard-mode vres window, inclusive (low bound)
//  V_STD_MAX     415  standard-mode vres window, inclusive (high bound)
//  NS_MIN        128  minimum hres and vres for non-standard mode
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high
//  ce          in   1   pixel-rate enable; all state advances only when ce=1
//  hsync_i     in   1   CRTC hsync, active high
//  vsync_i     in   1   CRTC vsync, active high
//  mode_o      out  2   0=ILLEGAL 1=STANDARD 2=NONSTD (3 never driven)
//  locked_o    out  1   1 while FSM is in LOCKED
//  hres_o      out  12  locked line length in dots
//  vres_o      out  9   locked field length in lines
//  mode_chg_o  out  1   one-clk pulse whenever mode_o changes value
// BEHAVIOUR
//  Reset and single clock:
//  - Single clock. Synchronous active-high reset.
//  - Reset values: mode_o=0, locked_o=0, hres_o=0, vres_o=0, mode_chg_o=0, FSM=SEARCH,
//    counters=0, edge registers=0.
//  Edges and measurement:
//  - Edges are registered on ce: hs_rise = hsync_i & ~hs_r; vs_rise likewise.
//  - dot_cnt is 12 bits and saturates at 4095. On hs_rise: h_meas <= dot_cnt, then dot_cnt <= 0.
//  - vs_rise sets field_pend. The next hs_rise with field_pend set is field end (fe):
//    v_meas = line_cnt+1, line_cnt <= 0, field_pend cleared.
//  - If vs_rise and hs_rise occur on the same ce, that hs_rise is already fe.
//  - line_cnt is 9 bits and saturates at 511. It increments on each non-fe hs_rise.
//  Classification (combinational on h_meas and v_meas):
//  - STANDARD if both values are inside their STD windows.
//  - Otherwise NONSTD if h_meas >= NS_MIN and v_meas >= NS_MIN.
//  - Otherwise ILLEGAL.
//  - match = |h_meas - ref_h| <= TOL_H && |v_meas - ref_v| <= TOL_V.
//  - Compute differences unsigned and widened by 1 bit; no wrap is allowed.
//  FSM (evaluated only on fe, except the watchdog):
//  - SEARCH: ref <= meas, lcnt <= 1, go to LOCKING.
//  - LOCKING, match: lcnt++. When lcnt+1 == LOCK_FIELDS, go to LOCKED and load hres_o/vres_o/mode_o
//    from ref and class.
//  - LOCKING, mismatch: ref <= meas, lcnt <= 1, stay in LOCKING.
//  - LOCKED, match: mcnt <= 0.
//  - LOCKED, mismatch: mcnt++. When mcnt+1 == UNLOCK_FIELDS, go to SEARCH and set locked_o=0.
//    mode_o, hres_o and vres_o are held.
//  - Watchdog (any state): line_cnt == 511 with no fe, or dot_cnt == 4095.
//    Go to SEARCH, mode_o <= ILLEGAL, locked_o <= 0, counters cleared.
//  Timing and pulse rules:
//  - Latency: registered outputs reflect fe on the clk after the fe ce-cycle.
//  - mode_chg_o is high for exactly one clk, in the same cycle mode_o takes its new value.
//  - Re-locking to the same mode gives no pulse.
//  - reset asserted mid-field discards the partial measurement; the first fe after reset only
//    enters LOCKING.
// STRUCTURE
//  - video_pkg holds: the mode_t enum (ILLEGAL/STANDARD/NONSTD), the fsm_t enum
//    (SEARCH/LOCKING/LOCKED), and the HRES_W=12 and VRES_W=9 localparams, shared with video_blanker.
//  - Sub-module sync_meter: edge detect, dot_cnt/line_cnt, h_meas/v_meas, fe strobe, watchdog
//    strobe.
//  - The top level holds the classifier, the FSM and the output registers.
// TESTING
//  1. 400x400 timing (hres=399, vres=399), 5 fields -> after fe #4: locked_o=1, mode_o=1,
//     hres_o=399, vres_o=399; one mode_chg_o.
//  2. Locked at 399x399, then one field with vres=300, then normal again -> stays LOCKED, no
//     pulse. Two consecutive bad fields -> locked_o=0, mode_o held.
//  3. Switch to hres=512, vres=260 -> 4 fields later mode_o=2, hres_o=512, vres_o=260, one pulse.
//  4. hsync stopped (dot_cnt reaches 4095) -> mode_o=0, locked_o=0, one pulse. Resume 399x399 ->
//     relock after 4 fields.
//  5. vs_rise and hs_rise on the same ce -> that edge ends the field, v_meas = line_cnt+1.
//     Jitter of +-2 dots is still accepted as a match.
//  6. reset pulsed mid-LOCKING -> all outputs 0. Lock is reached only at the 4th fe after reset.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and widths for the video timing path (mode controller and blanker).
package video_pkg;

  localparam int HRES_W = 12;
  localparam int VRES_W = 9;

  typedef enum logic [1:0] {
    ILLEGAL  = 2'd0,
    STANDARD = 2'd1,
    NONSTD   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } fsm_t;

endpackage

// File: rtl/sync_meter.sv
// Measures CRTC sync timing: line length in dots, field length in lines, field-end and
// watchdog strobes. All state advances on ce only.
module sync_meter
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              fe,
  output logic              wd,
  output logic [HRES_W-1:0] h_meas,
  output logic [VRES_W-1:0] v_meas
);

  localparam logic [HRES_W-1:0] DOT_MAX  = '1;
  localparam logic [VRES_W-1:0] LINE_MAX = '1;

  logic              hs_r;
  logic              vs_r;
  logic              field_pend;
  logic [HRES_W-1:0] dot_cnt;
  logic [VRES_W-1:0] line_cnt;
  logic [HRES_W-1:0] h_meas_r;
  logic [VRES_W-1:0] v_meas_r;
  logic              hs_rise;
  logic              vs_rise;
  logic              fe_raw;

  assign hs_rise = hsync_i & ~hs_r;
  assign vs_rise = vsync_i & ~vs_r;
  assign fe_raw  = ce & hs_rise & (field_pend | vs_rise);
  assign wd      = ce & ((dot_cnt == DOT_MAX) | ((line_cnt == LINE_MAX) & ~fe_raw));
  assign fe      = fe_raw & ~wd;

  // Present the fresh measurement in the fe cycle so the FSM acts on that same edge
  assign h_meas = (ce & hs_rise) ? dot_cnt : h_meas_r;
  assign v_meas = fe ? line_cnt + VRES_W'(1) : v_meas_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r       <= 1'b0;
      vs_r       <= 1'b0;
      field_pend <= 1'b0;
      dot_cnt    <= '0;
      line_cnt   <= '0;
    end else if (ce) begin
      hs_r <= hsync_i;
      vs_r <= vsync_i;
      if (wd) begin
        dot_cnt    <= '0;
        line_cnt   <= '0;
        field_pend <= 1'b0;
      end else begin
        if (hs_rise) begin
          h_meas_r <= dot_cnt;
          dot_cnt  <= '0;
        end else if (dot_cnt != DOT_MAX) begin
          dot_cnt <= dot_cnt + HRES_W'(1);
        end
        if (fe) begin
          v_meas_r   <= line_cnt + VRES_W'(1);
          line_cnt   <= '0;
          field_pend <= 1'b0;
        end else begin
          if (vs_rise) field_pend <= 1'b1;
          if (hs_rise && line_cnt != LINE_MAX) line_cnt <= line_cnt + VRES_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode decision: classifies measured sync timing and switches the blanker mode only
// after a stable lock, with hysteresis against single bad fields.
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int LOCK_FIELDS   = 4,
  parameter int UNLOCK_FIELDS = 2,
  parameter int TOL_H         = 2,
  parameter int TOL_V         = 1,
  parameter int H_STD_MIN     = 352,
  parameter int H_STD_MAX     = 415,
  parameter int V_STD_MIN     = 296,
  parameter int V_STD_MAX     = 415,
  parameter int NS_MIN        = 128
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic [1:0]        mode_o,
  output logic              locked_o,
  output logic [HRES_W-1:0] hres_o,
  output logic [VRES_W-1:0] vres_o,
  output logic              mode_chg_o
);

  localparam int PAD_V = HRES_W - VRES_W + 1;
  localparam logic [HRES_W-1:0] H_LO  = HRES_W'(H_STD_MIN);
  localparam logic [HRES_W-1:0] H_HI  = HRES_W'(H_STD_MAX);
  localparam logic [VRES_W-1:0] V_LO  = VRES_W'(V_STD_MIN);
  localparam logic [VRES_W-1:0] V_HI  = VRES_W'(V_STD_MAX);
  localparam logic [HRES_W-1:0] NS_H  = HRES_W'(NS_MIN);
  localparam logic [VRES_W-1:0] NS_V  = VRES_W'(NS_MIN);
  localparam logic [HRES_W:0]   TOL_HW = (HRES_W+1)'(TOL_H);
  localparam logic [HRES_W:0]   TOL_VW = (HRES_W+1)'(TOL_V);
  localparam logic [7:0]        LOCK_N   = 8'(LOCK_FIELDS);
  localparam logic [7:0]        UNLOCK_N = 8'(UNLOCK_FIELDS);

  // Differences are taken one bit wider than the operands so they never wrap
  function automatic logic [HRES_W:0] abs_diff(input logic [HRES_W:0] a,
                                               input logic [HRES_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic              fe;
  logic              wd;
  logic [HRES_W-1:0] h_meas;
  logic [VRES_W-1:0] v_meas;
  mode_t             cls;
  logic              match;
  fsm_t              state, state_nx;
  logic [HRES_W-1:0] ref_h, ref_h_nx;
  logic [VRES_W-1:0] ref_v, ref_v_nx;
  logic [7:0]        lcnt, lcnt_nx;
  logic [7:0]        mcnt, mcnt_nx;
  mode_t             mode_q, mode_nx;
  logic [HRES_W-1:0] hres_nx;
  logic [VRES_W-1:0] vres_nx;
  logic              locked_nx;
  logic              mode_chg_nx;

  sync_meter u_meter (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .fe      (fe),
    .wd      (wd),
    .h_meas  (h_meas),
    .v_meas  (v_meas)
  );

  always_comb begin
    if (h_meas >= H_LO && h_meas <= H_HI && v_meas >= V_LO && v_meas <= V_HI)
      cls = STANDARD;
    else if (h_meas >= NS_H && v_meas >= NS_V)
      cls = NONSTD;
    else
      cls = ILLEGAL;
    match = (abs_diff({1'b0, h_meas}, {1'b0, ref_h}) <= TOL_HW) &&
            (abs_diff({{PAD_V{1'b0}}, v_meas}, {{PAD_V{1'b0}}, ref_v}) <= TOL_VW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      lcnt       <= '0;
      mcnt       <= '0;
      mode_q     <= ILLEGAL;
      locked_o   <= 1'b0;
      hres_o     <= '0;
      vres_o     <= '0;
      mode_chg_o <= 1'b0;
    end else begin
      state      <= state_nx;
      lcnt       <= lcnt_nx;
      mcnt       <= mcnt_nx;
      mode_q     <= mode_nx;
      locked_o   <= locked_nx;
      hres_o     <= hres_nx;
      vres_o     <= vres_nx;
      mode_chg_o <= mode_chg_nx;
    end
    ref_h <= ref_h_nx;
    ref_v <= ref_v_nx;
  end

  // Decisions are taken only at field end; the watchdog overrides from any state
  always_comb begin
    state_nx = state;
    ref_h_nx = ref_h;
    ref_v_nx = ref_v;
    lcnt_nx  = lcnt;
    mcnt_nx  = mcnt;
    mode_nx  = mode_q;
    hres_nx  = hres_o;
    vres_nx  = vres_o;
    if (wd) begin
      state_nx = SEARCH;
      mode_nx  = ILLEGAL;
      lcnt_nx  = '0;
      mcnt_nx  = '0;
    end else if (fe) begin
      case (state)
        SEARCH: begin
          ref_h_nx = h_meas;
          ref_v_nx = v_meas;
          lcnt_nx  = 8'd1;
          state_nx = LOCKING;
        end
        LOCKING: begin
          if (match) begin
            lcnt_nx = lcnt + 8'd1;
            if (lcnt + 8'd1 == LOCK_N) begin
              state_nx = LOCKED;
              mcnt_nx  = '0;
              hres_nx  = ref_h;
              vres_nx  = ref_v;
              mode_nx  = cls;
            end
          end else begin
            ref_h_nx = h_meas;
            ref_v_nx = v_meas;
            lcnt_nx  = 8'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            mcnt_nx = '0;
          end else begin
            mcnt_nx = mcnt + 8'd1;
            if (mcnt + 8'd1 == UNLOCK_N) begin
              state_nx = SEARCH;
              mcnt_nx  = '0;
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_nx   = (state_nx == LOCKED);
    mode_chg_nx = (mode_nx != mode_q);
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed-sequence bench with random ce gaps and line jitter, checked against an
// event-level model of field measurement and lock hysteresis.
module tb_video_mode_ctrl;

  localparam int LOCK_F = 4, UNLOCK_F = 2, TOLH = 2, TOLV = 1;
  localparam int HMIN = 24, HMAX = 31, VMIN = 10, VMAX = 15, NSMIN = 8;

  logic        clk = 1'b0;
  logic        reset, ce, hsync_i, vsync_i;
  logic [1:0]  mode_o;
  logic        locked_o;
  logic [11:0] hres_o;
  logic [8:0]  vres_o;
  logic        mode_chg_o;

  int total = 0, bad = 0, clk_cnt = 0;
  int m_idx, m_last_hs, m_lines, obs_pulses = 0, e_pulses = 0;
  bit m_prev_hs, m_prev_vs, m_pend;
  int r_h, r_v, agree, misses, e_mode, e_hres, e_vres;
  bit m_locked;

  video_mode_ctrl #(
    .LOCK_FIELDS(LOCK_F), .UNLOCK_FIELDS(UNLOCK_F), .TOL_H(TOLH), .TOL_V(TOLV),
    .H_STD_MIN(HMIN), .H_STD_MAX(HMAX), .V_STD_MIN(VMIN), .V_STD_MAX(VMAX), .NS_MIN(NSMIN)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .mode_o(mode_o), .locked_o(locked_o), .hres_o(hres_o), .vres_o(vres_o),
    .mode_chg_o(mode_chg_o)
  );

  always #5 clk = ~clk;

  function automatic int classify(input int h, input int v);
    if (h >= HMIN && h <= HMAX && v >= VMIN && v <= VMAX) return 1;
    if (h >= NSMIN && v >= NSMIN) return 2;
    return 0;
  endfunction

  function automatic bit close_to_ref(input int h, input int v);
    int dh, dv;
    dh = (h > r_h) ? h - r_h : r_h - h;
    dv = (v > r_v) ? v - r_v : r_v - v;
    return (dh <= TOLH) && (dv <= TOLV);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input int m);
    if (m != e_mode) e_pulses++;
    e_mode = m;
  endtask

  task automatic model_reset();
    m_idx = 0; m_last_hs = -1; m_lines = 0;
    m_prev_hs = 0; m_prev_vs = 0; m_pend = 0;
    agree = 0; misses = 0; m_locked = 0;
    e_mode = 0; e_hres = 0; e_vres = 0;
  endtask

  task automatic model_field(input int h, input int v);
    if (!m_locked) begin
      if (agree == 0 || !close_to_ref(h, v)) begin
        r_h = h; r_v = v; agree = 1;
      end else begin
        agree++;
        if (agree == LOCK_F) begin
          m_locked = 1; misses = 0;
          e_hres = r_h; e_vres = r_v;
          set_mode(classify(h, v));
        end
      end
    end else if (close_to_ref(h, v)) begin
      misses = 0;
    end else begin
      misses++;
      if (misses == UNLOCK_F) begin
        m_locked = 0; agree = 0; misses = 0;
      end
    end
  endtask

  // One enabled pixel step, described by edge events and elapsed ce-cycle counts
  task automatic model_ce(input bit hs, input bit vs);
    bit hr, vr, fe, wd;
    int dots;
    hr = hs && !m_prev_hs;
    vr = vs && !m_prev_vs;
    dots = m_idx - m_last_hs - 1;
    if (dots > 4095) dots = 4095;
    fe = hr && (m_pend || vr);
    wd = (dots == 4095) || (m_lines == 511 && !fe);
    if (wd) begin
      m_last_hs = m_idx; m_lines = 0; m_pend = 0;
      m_locked = 0; agree = 0; misses = 0;
      set_mode(0);
    end else begin
      if (hr) m_last_hs = m_idx;
      if (fe) begin
        model_field(dots, m_lines + 1);
        m_lines = 0; m_pend = 0;
      end else begin
        if (vr) m_pend = 1;
        if (hr && m_lines < 511) m_lines++;
      end
    end
    m_prev_hs = hs; m_prev_vs = vs;
    m_idx++;
  endtask

  task automatic tick(input logic hs, input logic vs);
    logic c;
    do begin
      c = ($urandom_range(0, 7) != 0);
      ce = c; hsync_i = hs; vsync_i = vs;
      @(posedge clk); #1;
      clk_cnt++;
      if (clk_cnt > 90000) begin
        $display("FAIL timeout: cycles=%0d limit=90000", clk_cnt);
        $fatal(1, "cycle budget exhausted");
      end
      if (c) model_ce(hs, vs);
      obs_pulses += int'(mode_chg_o);
    end while (!c);
  endtask

  // Drives nl lines of a field; vsync either mid last line or together with line 0 hsync
  task automatic run_field(input int h, input int v, input int jit, input bit same,
                           input bit skip, input int nl);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = h + 1;
      if (jit > 0) len += int'($urandom_range(0, 2 * jit)) - jit;
      for (int c = 0; c < len; c++) begin
        logic hs, vs;
        hs = (c < 3) && !(skip && l == 0);
        vs = same ? (l == 0 && c < 3) : (l == v - 1 && c >= 4 && c < 7);
        tick(hs, vs);
      end
    end
  endtask

  task automatic fields(input int n, input int h, input int v, input int jit, input bit same);
    for (int i = 0; i < n; i++) run_field(h, v, jit, same, 1'b0, v);
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mode"}, int'(mode_o), e_mode);
    chk({tag, ".locked"}, int'(locked_o), int'(m_locked));
    chk({tag, ".hres"}, int'(hres_o), e_hres);
    chk({tag, ".vres"}, int'(vres_o), e_vres);
    chk({tag, ".pulses"}, obs_pulses, e_pulses);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mode"}, int'(mode_o), 0);
    chk({tag, ".locked"}, int'(locked_o), 0);
    chk({tag, ".hres"}, int'(hres_o), 0);
    chk({tag, ".vres"}, int'(vres_o), 0);
    chk({tag, ".chg"}, int'(mode_chg_o), 0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    do_reset();
    check_zero("reset");

    // Standard timing: lock at the 4th field end
    run_field(27, 12, 0, 1'b0, 1'b1, 12);
    fields(3, 27, 12, 0, 1'b0);
    chk("t1.unlocked_fe3", int'(locked_o), 0);
    check_model("t1.fe3");
    fields(1, 27, 12, 0, 1'b0);
    chk("t1.locked", int'(locked_o), 1);
    chk("t1.mode", int'(mode_o), 1);
    chk("t1.hres", int'(hres_o), 27);
    chk("t1.vres", int'(vres_o), 12);
    chk("t1.pulses", obs_pulses, 1);
    fields(1, 27, 12, 0, 1'b0);
    check_model("t1.end");

    // One bad field is tolerated, two consecutive drop lock with mode held
    fields(1, 27, 20, 0, 1'b0);
    fields(1, 27, 12, 0, 1'b0);
    chk("t2.hold_locked", int'(locked_o), 1);
    chk("t2.hold_pulses", obs_pulses, 1);
    fields(2, 27, 20, 0, 1'b0);
    fields(1, 27, 12, 0, 1'b0);
    chk("t2.unlocked", int'(locked_o), 0);
    chk("t2.mode_held", int'(mode_o), 1);
    check_model("t2.end");

    // Non-standard timing
    fields(5, 40, 9, 0, 1'b0);
    chk("t3.mode", int'(mode_o), 2);
    chk("t3.hres", int'(hres_o), 40);
    chk("t3.vres", int'(vres_o), 9);
    chk("t3.pulses", obs_pulses, 2);
    check_model("t3.end");

    // hsync stops: dot watchdog forces ILLEGAL, then relock
    for (int i = 0; i < 4200; i++) tick(1'b0, 1'b0);
    chk("t4.wd_mode", int'(mode_o), 0);
    chk("t4.wd_locked", int'(locked_o), 0);
    chk("t4.wd_pulses", obs_pulses, 3);
    run_field(27, 12, 0, 1'b0, 1'b1, 12);
    fields(3, 27, 12, 0, 1'b0);
    chk("t4.fe3_locked", int'(locked_o), 0);
    fields(1, 27, 12, 0, 1'b0);
    chk("t4.relocked", int'(locked_o), 1);
    chk("t4.mode", int'(mode_o), 1);
    check_model("t4.end");

    // Coincident vsync/hsync edges, line jitter within tolerance, relock at V_STD_MAX
    fields(4, 27, 12, 2, 1'b1);
    chk("t5.jit_locked", int'(locked_o), 1);
    chk("t5.jit_pulses", obs_pulses, 4);
    fields(7, 27, 15, 0, 1'b1);
    chk("t5.vres15", int'(vres_o), 15);
    chk("t5.locked15", int'(locked_o), 1);
    chk("t5.same_mode_no_pulse", obs_pulses, 4);
    check_model("t5.end");

    // Reset in the middle of LOCKING
    fields(4, 40, 9, 0, 1'b0);
    run_field(40, 9, 0, 1'b0, 1'b0, 4);
    do_reset();
    check_zero("t6.reset");
    run_field(40, 9, 0, 1'b0, 1'b1, 9);
    fields(3, 40, 9, 0, 1'b0);
    chk("t6.fe3_locked", int'(locked_o), 0);
    fields(1, 40, 9, 0, 1'b0);
    chk("t6.locked", int'(locked_o), 1);
    chk("t6.mode", int'(mode_o), 2);
    check_model("t6.end");

    // hres one below NS_MIN locks as ILLEGAL
    fields(7, 7, 12, 0, 1'b0);
    chk("t7.mode", int'(mode_o), 0);
    chk("t7.locked", int'(locked_o), 1);
    chk("t7.hres", int'(hres_o), 7);
    chk("t7.pulses", obs_pulses, 6);
    check_model("t7.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
